// File: rtl/mbc_pkg.sv
// Shared types and constants for the MBC5 SRAM arbiter.
// State encoding and counter sizing helper.
package mbc_pkg;

  localparam int SRAM_AW = 17;
  localparam logic [2:0] GB_SRAM_WIN = 3'b101;

  localparam int GUARD_CYCLES_D = 2;
  localparam int HOST_ACC_CYCLES_D = 3;

  typedef enum logic [2:0] {
    IDLE,
    GB_OWN,
    GUARD,
    H_SETUP,
    H_ACCESS,
    H_DONE
  } state_t;

  // Counters hold at most max(g,h)-1.
  function automatic int cnt_w(input int g, input int h);
    int m;
    m = (g > h) ? g : h;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  localparam int CNT_W = cnt_w(GUARD_CYCLES_D, HOST_ACC_CYCLES_D);

endpackage

// File: rtl/mbc_sync.sv
// Multi-flop synchroniser for the asynchronous GB strobe.
// Synchronous active-low reset clears every stage.
module mbc_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // Shift d in at bit 0, output from the top stage.
  always_ff @(posedge clk) begin
    if (!rst_n) ff <= '0;
    else        ff <= STAGES'({ff, d});
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/mbc_sram_arbiter.sv
// Shares battery SRAM between the GB bus and a host backup port.
// GB always wins via a combinational pin override.
module mbc_sram_arbiter
  import mbc_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int GUARD_CYCLES    = GUARD_CYCLES_D,
  parameter int HOST_ACC_CYCLES = HOST_ACC_CYCLES_D
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               gb_cs_n,
  input  logic [15:0]        gb_addr,
  input  logic [3:0]         ram_bank,
  input  logic               ram_enable,
  input  logic               host_req,
  input  logic               host_we,
  input  logic [SRAM_AW-1:0] host_addr,
  input  logic [7:0]         host_wdata,
  output logic               host_ack,
  output logic               host_abort,
  output logic [7:0]         host_rdata,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic [7:0]         sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [7:0]         sram_dq_in
);

  localparam int CW = cnt_w(GUARD_CYCLES, HOST_ACC_CYCLES);
  localparam logic [CW-1:0] G_LD = CW'(GUARD_CYCLES - 1);
  localparam logic [CW-1:0] A_LD = CW'(HOST_ACC_CYCLES - 1);

  logic gb_sel_raw;
  logic gb_sel_s;

  assign gb_sel_raw = ~gb_cs_n & (gb_addr[15:13] == GB_SRAM_WIN);

  mbc_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (gb_sel_raw),
    .q     (gb_sel_s)
  );

  state_t           st, st_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             ack_nx, abort_nx, cap;
  logic [SRAM_AW-1:0] addr_q;
  logic             ce_q, oe_q, we_q, dqoe_q;

  // Next-state, counters and the ack/abort/capture decisions.
  always_comb begin
    st_nx    = st;
    cnt_nx   = cnt;
    ack_nx   = 1'b0;
    abort_nx = 1'b0;
    cap      = 1'b0;
    unique case (st)
      IDLE: begin
        if (gb_sel_s)      st_nx = GB_OWN;
        else if (host_req) st_nx = H_SETUP;
      end
      GB_OWN: begin
        if (!gb_sel_s) begin
          st_nx  = GUARD;
          cnt_nx = G_LD;
        end
      end
      GUARD: begin
        if (gb_sel_s)        st_nx = GB_OWN;
        else if (cnt == '0)  st_nx = host_req ? H_SETUP : IDLE;
        else                 cnt_nx = cnt - 1'b1;
      end
      H_SETUP: begin
        if (gb_sel_s) begin
          st_nx    = GB_OWN;
          abort_nx = 1'b1;
        end else begin
          st_nx  = H_ACCESS;
          cnt_nx = A_LD;
        end
      end
      H_ACCESS: begin
        if (gb_sel_s) begin
          st_nx    = GB_OWN;
          abort_nx = 1'b1;
        end else if (cnt == '0) begin
          st_nx  = H_DONE;
          ack_nx = 1'b1;
          cap    = ~host_we;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      H_DONE: begin
        // Ack already issued on entry; a GB claim here loses nothing.
        if (gb_sel_s) st_nx = GB_OWN;
        else begin
          st_nx  = GUARD;
          cnt_nx = G_LD;
        end
      end
      default: st_nx = IDLE;
    endcase
  end

  // State plus registered pin values decoded from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st          <= IDLE;
      cnt         <= '0;
      host_ack    <= 1'b0;
      host_abort  <= 1'b0;
      host_rdata  <= '0;
      addr_q      <= '0;
      sram_dq_out <= '0;
      ce_q        <= 1'b1;
      oe_q        <= 1'b1;
      we_q        <= 1'b1;
      dqoe_q      <= 1'b0;
    end else begin
      st         <= st_nx;
      cnt        <= cnt_nx;
      host_ack   <= ack_nx;
      host_abort <= abort_nx;
      if (cap) host_rdata <= sram_dq_in;
      if (st_nx == H_SETUP) begin
        addr_q      <= host_addr;
        sram_dq_out <= host_wdata;
      end
      ce_q   <= !(st_nx inside {H_SETUP, H_ACCESS});
      oe_q   <= !((st_nx == H_ACCESS) && !host_we);
      we_q   <= !((st_nx == H_ACCESS) && host_we);
      dqoe_q <= host_we && (st_nx inside {H_SETUP, H_ACCESS, H_DONE});
    end
  end

  assign sram_addr  = gb_sel_raw ? {ram_bank, gb_addr[12:0]} : addr_q;
  assign sram_ce_n  = gb_sel_raw ? ~ram_enable : ce_q;
  assign sram_oe_n  = gb_sel_raw | oe_q;
  assign sram_we_n  = gb_sel_raw | we_q;
  assign sram_dq_oe = ~gb_sel_raw & dqoe_q;

endmodule

// File: tb/tb_mbc_sram_arbiter.sv
// Directed bench for mbc_sram_arbiter.
// Override vector table plus cycle-traced host scenarios.
module tb_mbc_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        gb_cs_n = 1'b1;
  logic [15:0] gb_addr = 16'h0000;
  logic [3:0]  ram_bank = 4'h0;
  logic        ram_enable = 1'b0;
  logic        host_req = 1'b0;
  logic        host_we = 1'b0;
  logic [16:0] host_addr = '0;
  logic [7:0]  host_wdata = '0;
  logic        host_ack, host_abort;
  logic [7:0]  host_rdata;
  logic [16:0] sram_addr;
  logic        sram_ce_n, sram_oe_n, sram_we_n;
  logic [7:0]  sram_dq_out;
  logic        sram_dq_oe;
  logic [7:0]  sram_dq_in = '0;

  int n_tests = 0;
  int n_fail = 0;

  mbc_sram_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .gb_cs_n(gb_cs_n), .gb_addr(gb_addr),
    .ram_bank(ram_bank), .ram_enable(ram_enable),
    .host_req(host_req), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_abort(host_abort),
    .host_rdata(host_rdata),
    .sram_addr(sram_addr), .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Runs n cycles from a negedge; bit c of each mask is cycle c.
  // Strobe column is we_n for writes, oe_n for reads.
  task automatic trace(input string nm, input int n,
                       input logic [15:0] ece, input logic [15:0] es,
                       input logic [15:0] eack, input logic [15:0] eab,
                       input int gon, input int goff, input int ron,
                       input int rst_c, input bit b2b,
                       input logic [7:0] erd, input logic [16:0] a2,
                       input logic [7:0] d2);
    int acks = 0;
    int bad = 0;
    bit post = 0;
    logic [7:0] rd0;
    logic s;
    rd0 = host_rdata;
    for (int c = 0; c <= n; c++) begin
      if (c > 0) begin
        @(negedge clk);
        s = host_we ? sram_we_n : sram_oe_n;
        chk($sformatf("%s c%0d", nm, c),
            {28'd0, sram_ce_n, s, host_ack, host_abort},
            {28'd0, ece[c], es[c], eack[c], eab[c]});
        if (host_we ? !sram_oe_n : !sram_we_n) bad++;
        if (!sram_we_n && !(sram_dq_oe && sram_dq_out == host_wdata))
          bad++;
        if (!sram_ce_n && gb_cs_n && sram_addr != host_addr) bad++;
        if (post && host_we && sram_dq_oe) bad++;
        post = 0;
        if (c == rst_c + 1)
          chk({nm, " rstval"},
              {sram_we_n, sram_ce_n, sram_dq_oe, host_ack, host_abort,
               sram_dq_out, host_rdata, 7'd0, sram_addr},
              {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 7'd0, 17'h0});
        if (host_abort)
          chk({nm, " abort rdata"}, {24'd0, host_rdata}, {24'd0, rd0});
        if (host_ack) begin
          chk($sformatf("%s rdata%0d", nm, acks), {24'd0, host_rdata},
              {24'd0, (acks == 0) ? erd : d2});
          if (host_we && !sram_dq_oe) bad++;
          post = 1;
          acks++;
          if (b2b && acks == 1) begin
            host_addr  = a2;
            sram_dq_in = d2;
          end else begin
            host_req = 0;
          end
        end
      end
      if (c == gon)  gb_cs_n = 1'b0;
      if (c == goff) gb_cs_n = 1'b1;
      if (c == ron)  host_req = 1'b1;
      rst_n = (c == rst_c) ? 1'b0 : 1'b1;
    end
    chk({nm, " pins"}, bad, 0);
  endtask

  typedef struct {
    logic        cs_n;
    logic [15:0] a;
    logic [3:0]  bank;
    logic        en;
    logic [16:0] e_addr;
    logic        e_ce;
  } ov_t;

  ov_t ov[7];

  initial begin
    ov[0] = '{1'b0, 16'hA123, 4'h7, 1'b1, 17'h0E123, 1'b0};
    ov[1] = '{1'b0, 16'hA123, 4'h7, 1'b0, 17'h0E123, 1'b1};
    ov[2] = '{1'b1, 16'hA123, 4'h7, 1'b1, 17'h00000, 1'b1};
    ov[3] = '{1'b0, 16'hC123, 4'h7, 1'b1, 17'h00000, 1'b1};
    ov[4] = '{1'b0, 16'hBFFF, 4'hF, 1'b1, 17'h1FFFF, 1'b0};
    ov[5] = '{1'b0, 16'hA000, 4'h0, 1'b1, 17'h00000, 1'b0};
    ov[6] = '{1'b0, 16'h9FFF, 4'h3, 1'b1, 17'h00000, 1'b1};

    repeat (3) @(negedge clk);
    chk("reset strobes",
        {28'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe},
        {28'd0, 4'b1110});
    chk("reset addr", {15'd0, sram_addr}, 32'd0);
    chk("reset ackab", {30'd0, host_ack, host_abort}, 32'd0);
    chk("reset data", {16'd0, host_rdata, sram_dq_out}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      gb_cs_n    = ov[i].cs_n;
      gb_addr    = ov[i].a;
      ram_bank   = ov[i].bank;
      ram_enable = ov[i].en;
      #1;
      chk($sformatf("override v%0d", i),
          {11'd0, sram_addr, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe},
          {11'd0, ov[i].e_addr, ov[i].e_ce, 3'b110});
      @(negedge clk);
    end
    gb_cs_n  = 1'b1;
    gb_addr  = 16'hA000;
    ram_bank = 4'h0;
    repeat (8) @(negedge clk);

    host_we = 0; host_addr = 17'h1ABCD; sram_dq_in = 8'h5A;
    trace("read", 6, 16'h0060, 16'h0062, 16'h0020, 16'h0000,
          -1, -1, 0, -1, 0, 8'h5A, 17'h0, 8'h0);
    repeat (5) @(negedge clk);

    host_we = 1; host_addr = 17'h00123; host_wdata = 8'hC3;
    trace("write", 6, 16'h0060, 16'h0062, 16'h0020, 16'h0000,
          -1, -1, 0, -1, 0, 8'h5A, 17'h0, 8'h0);
    repeat (5) @(negedge clk);

    host_we = 0; host_addr = 17'h04444; sram_dq_in = 8'h77;
    ram_enable = 1;
    trace("abort", 14, 16'h61E0, 16'h63FE, 16'h2000, 16'h0010,
          1, 4, 0, -1, 0, 8'h77, 17'h0, 8'h0);
    repeat (5) @(negedge clk);

    host_addr = 17'h08888; sram_dq_in = 8'h3C;
    ram_enable = 0;
    trace("contend", 15, 16'hC3FE, 16'hC7FE, 16'h4000, 16'h0000,
          0, 5, 2, -1, 0, 8'h3C, 17'h0, 8'h0);
    repeat (5) @(negedge clk);

    host_addr = 17'h00010; sram_dq_in = 8'h11;
    trace("b2b", 13, 16'h30E0, 16'h31E2, 16'h1020, 16'h0000,
          -1, -1, 0, -1, 1, 8'h11, 17'h1FFFF, 8'h99);
    repeat (5) @(negedge clk);

    host_we = 1; host_addr = 17'h15555; host_wdata = 8'hA5;
    trace("rstmid", 9, 16'h0308, 16'h031A, 16'h0100, 16'h0000,
          -1, -1, 0, 2, 0, 8'h00, 17'h0, 8'h0);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
